sfq_dff_pulse_scheduler: RTL and testbench

//   Clocked scheduler that shares one RSFQ DFF storage cell (set/reset pulse inputs, toggling out)

---
 rtl/sfq_dff_pulse_scheduler_if.sv | 26 ++
 rtl/sfq_dff_pulse_scheduler.sv | 159 +++++++++++++++
 tb/tb_sfq_dff_pulse_scheduler.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sfq_dff_pulse_scheduler_if.sv
// Request/grant and pulse bundle between test sequencers and the SFQ DFF pulse scheduler.
// The master side raises requests and observes pulses; the slave side is the scheduler.
interface sfq_dff_pulse_scheduler_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0] wr_req;
  logic [NUM_REQ-1:0] wr_gnt;
  logic               rd_req;
  logic               rd_gnt;
  logic               set_pulse;
  logic               reset_pulse;
  logic               rd_empty;
  logic               out_expect;
  logic               out_level;
  logic               cell_full;

  modport master (
    output wr_req, rd_req,
    input  wr_gnt, rd_gnt, set_pulse, reset_pulse, rd_empty, out_expect, out_level, cell_full
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_gnt, rd_gnt, set_pulse, reset_pulse, rd_empty, out_expect, out_level, cell_full
  );
endinterface

// File: rtl/sfq_dff_pulse_scheduler.sv
// Shares one RSFQ DFF cell among NUM_REQ writers and one reader, issuing only legal set/reset
// pulses and predicting the cell output toggle DELAY_OUT cycles after each full-cell reset.
module sfq_dff_pulse_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CT_SET_RESET = 2,
  parameter int CT_RESET_SET = 1,
  parameter int DELAY_OUT    = 7,
  parameter int CNT_W        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  sfq_dff_pulse_scheduler_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    ST_EMPTY     = 2'd0,
    ST_GUARD_SET = 2'd1,
    ST_FULL      = 2'd2,
    ST_GUARD_RST = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [PTR_W-1:0]   win_idx, win_next;
  logic               win_found;
  int                 rr_idx;
  logic [NUM_REQ-1:0] wr_gnt_q, wr_gnt_d;
  logic               rd_gnt_q, rd_gnt_d;
  logic               set_pulse_q, set_pulse_d;
  logic               reset_pulse_q, reset_pulse_d;
  logic               rd_empty_q, rd_empty_d;
  logic               cell_full_q, cell_full_d;
  logic               out_level_q, out_level_d;
  logic [DELAY_OUT-1:0] pipe_q, pipe_d;

  // Descending scan so the last hit is the lowest offset from the pointer.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    rr_idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      rr_idx = (int'(ptr_q) + off) % NUM_REQ;
      if (bus.wr_req[rr_idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(rr_idx);
      end
    end
    win_next = (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + PTR_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ptr_d         = ptr_q;
    wr_gnt_d      = '0;
    rd_gnt_d      = 1'b0;
    set_pulse_d   = 1'b0;
    reset_pulse_d = 1'b0;
    rd_empty_d    = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (win_found) begin
          wr_gnt_d    = NUM_REQ'(1) << win_idx;
          set_pulse_d = 1'b1;
          ptr_d       = win_next;
          if (CT_SET_RESET == 0) begin
            state_d = ST_FULL;
          end else begin
            state_d = ST_GUARD_SET;
            cnt_d   = CNT_W'(CT_SET_RESET);
          end
        end else if (bus.rd_req) begin
          rd_gnt_d      = 1'b1;
          reset_pulse_d = 1'b1;
          rd_empty_d    = 1'b1;
        end
      end
      ST_GUARD_SET: begin
        // The decrement that reaches zero lands directly in the next state.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_FULL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_FULL: begin
        if (bus.rd_req) begin
          rd_gnt_d      = 1'b1;
          reset_pulse_d = 1'b1;
          if (CT_RESET_SET == 0) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_GUARD_RST;
            cnt_d   = CNT_W'(CT_RESET_SET);
          end
        end
      end
      default: begin
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_EMPTY;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    endcase
    cell_full_d = (state_d == ST_FULL) || (state_d == ST_GUARD_SET);
  end

  // Delay pipe fed one cycle after a full-cell reset pulse; the tail is out_expect.
  assign pipe_d[0] = reset_pulse_q & ~rd_empty_q;
  generate
    for (genvar gi = 1; gi < DELAY_OUT; gi++) begin : g_pipe
      assign pipe_d[gi] = pipe_q[gi-1];
    end
  endgenerate

  assign out_level_d = out_level_q ^ pipe_d[DELAY_OUT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_EMPTY;
      cnt_q         <= '0;
      ptr_q         <= '0;
      wr_gnt_q      <= '0;
      rd_gnt_q      <= 1'b0;
      set_pulse_q   <= 1'b0;
      reset_pulse_q <= 1'b0;
      rd_empty_q    <= 1'b0;
      cell_full_q   <= 1'b0;
      out_level_q   <= 1'b0;
      pipe_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ptr_q         <= ptr_d;
      wr_gnt_q      <= wr_gnt_d;
      rd_gnt_q      <= rd_gnt_d;
      set_pulse_q   <= set_pulse_d;
      reset_pulse_q <= reset_pulse_d;
      rd_empty_q    <= rd_empty_d;
      cell_full_q   <= cell_full_d;
      out_level_q   <= out_level_d;
      pipe_q        <= pipe_d;
    end
  end

  assign bus.wr_gnt      = wr_gnt_q;
  assign bus.rd_gnt      = rd_gnt_q;
  assign bus.set_pulse   = set_pulse_q;
  assign bus.reset_pulse = reset_pulse_q;
  assign bus.rd_empty    = rd_empty_q;
  assign bus.cell_full   = cell_full_q;
  assign bus.out_level   = out_level_q;
  assign bus.out_expect  = pipe_q[DELAY_OUT-1];
endmodule

// File: tb/tb_sfq_dff_pulse_scheduler.sv
// Scenario bench for the SFQ DFF pulse scheduler: grant and out_expect scoreboards
// are filled by the scenarios and drained by a negedge monitor.
module tb_sfq_dff_pulse_scheduler;
  localparam int NUM_REQ      = 4;
  localparam int CT_SET_RESET = 2;
  localparam int CT_RESET_SET = 1;
  localparam int DELAY_OUT    = 7;
  localparam int CNT_W        = 4;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  int   oe_seen;
  logic exp_level;
  logic [NUM_REQ-1:0] gnt_q[$];
  int                 oe_q[$];

  sfq_dff_pulse_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  sfq_dff_pulse_scheduler #(
    .NUM_REQ(NUM_REQ), .CT_SET_RESET(CT_SET_RESET), .CT_RESET_SET(CT_RESET_SET),
    .DELAY_OUT(DELAY_OUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic monitor();
    logic [NUM_REQ-1:0] eg;
    int et;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.set_pulse && bus.reset_pulse) begin
          checks++; failures++;
          $display("FAIL pulse_overlap cyc=%0d set and reset both high, required at most one", cyc);
        end
        if (bus.set_pulse) begin
          checks++;
          if (gnt_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_grant cyc=%0d wr_gnt=%b, required no set_pulse", cyc, bus.wr_gnt);
          end else begin
            eg = gnt_q.pop_front();
            if (bus.wr_gnt !== eg) begin
              failures++;
              $display("FAIL wr_gnt cyc=%0d got=%b required=%b", cyc, bus.wr_gnt, eg);
            end else $display("grant cyc=%0d wr_gnt=%b", cyc, bus.wr_gnt);
          end
        end
        if (bus.out_expect) begin
          oe_seen++;
          exp_level = ~exp_level;
          checks++;
          if (oe_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_out_expect cyc=%0d, required none", cyc);
          end else begin
            et = oe_q.pop_front();
            if (et != cyc) begin
              failures++;
              $display("FAIL out_expect_time got cyc=%0d required cyc=%0d", cyc, et);
            end else $display("out_expect cyc=%0d level=%b", cyc, bus.out_level);
          end
          checks++;
          if (bus.out_level !== exp_level) begin
            failures++;
            $display("FAIL out_level cyc=%0d got=%b required=%b", cyc, bus.out_level, exp_level);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst_n      = 1'b0;
    bus.wr_req = '0;
    bus.rd_req = 1'b0;
    gnt_q.delete();
    oe_q.delete();
    exp_level  = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_set(input int budget, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.set_pulse) begin at = cyc; ok = 1'b1; break; end
    end
  endtask

  task automatic wait_rst(input int budget, output int at, output bit ok);
    ok = 1'b0; at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.reset_pulse) begin at = cyc; ok = 1'b1; break; end
    end
  endtask

  task automatic do_write(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] exp_g,
                          output int at);
    bit ok;
    gnt_q.push_back(exp_g);
    bus.wr_req = mask;
    wait_set(30, at, ok);
    bus.wr_req = '0;
    checks++;
    if (!ok) begin failures++; $display("FAIL write_timeout got=no set_pulse required=set_pulse"); end
  endtask

  task automatic do_read(input bit full, output int at);
    bit ok;
    bus.rd_req = 1'b1;
    wait_rst(30, at, ok);
    bus.rd_req = 1'b0;
    checks++;
    if (!ok) begin
      failures++; $display("FAIL read_timeout got=no reset_pulse required=reset_pulse");
    end else begin
      $display("read cyc=%0d rd_empty=%b", at, bus.rd_empty);
      if (full) oe_q.push_back(at + DELAY_OUT);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; bus.wr_req = '0; bus.rd_req = 1'b0; exp_level = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.set_pulse, bus.reset_pulse, bus.rd_gnt, bus.rd_empty, bus.out_expect} !== 5'b0 ||
        bus.wr_gnt !== '0) begin
      failures++; $display("FAIL reset_strobes got nonzero required all 0");
    end
    checks++;
    if (bus.out_level !== 1'b0 || bus.cell_full !== 1'b0) begin
      failures++; $display("FAIL reset_level got out_level=%b cell_full=%b required 0 0", bus.out_level, bus.cell_full);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.set_pulse !== 1'b0 || bus.cell_full !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset got set=%b full=%b required 0 0", bus.set_pulse, bus.cell_full);
    end
    $display("reset done cyc=%0d", cyc);
  endtask

  task automatic test_write_guard();
    int c0, ts, tr;
    c0 = cyc;
    do_write(4'b0001, 4'b0001, ts);
    checks++;
    if (ts != c0 + 1) begin failures++; $display("FAIL set_latency got cyc=%0d required cyc=%0d", ts, c0 + 1); end
    checks++;
    if (bus.cell_full !== 1'b1) begin failures++; $display("FAIL cell_full_after_set got=%b required=1", bus.cell_full); end
    do_read(1'b1, tr);
    // rd_req was waiting throughout, so the reset lands at the earliest legal cycle.
    checks++;
    if (tr - ts != CT_SET_RESET + 1) begin
      failures++; $display("FAIL set_to_reset_gap got=%0d required=%0d", tr - ts, CT_SET_RESET + 1);
    end
    checks++;
    if (bus.rd_empty !== 1'b0) begin failures++; $display("FAIL rd_empty_full got=%b required=0", bus.rd_empty); end
    repeat (DELAY_OUT + 3) @(negedge clk);
  endtask

  task automatic test_out_expect();
    int t;
    apply_reset();
    do_write(4'b0001, 4'b0001, t);
    do_read(1'b1, t);
    repeat (DELAY_OUT + 2) @(negedge clk);
    checks++;
    if (bus.out_level !== 1'b1) begin failures++; $display("FAIL out_level_first got=%b required=1", bus.out_level); end
    do_write(4'b0100, 4'b0100, t);
    do_read(1'b1, t);
    repeat (DELAY_OUT + 2) @(negedge clk);
    checks++;
    if (bus.out_level !== 1'b0) begin failures++; $display("FAIL out_level_second got=%b required=0", bus.out_level); end
  endtask

  task automatic test_back_to_back();
    int t;
    bit ok;
    logic [NUM_REQ-1:0] seq [5];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
    apply_reset();
    for (int i = 0; i < 5; i++) gnt_q.push_back(seq[i]);
    bus.wr_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_set(30, t, ok);
      if (i == 4) bus.wr_req = '0;
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_set_timeout idx=%0d got=none required=set_pulse", i); end
      do_read(1'b1, t);
    end
    bus.wr_req = '0;
    repeat (DELAY_OUT + 3) @(negedge clk);
  endtask

  task automatic test_full_stall();
    int t, tr, ts;
    bit ok;
    apply_reset();
    do_write(4'b0001, 4'b0001, t);
    bus.wr_req = 4'b0010;
    wait_set(20, t, ok);
    checks++;
    if (ok) begin failures++; $display("FAIL full_stall got set_pulse at cyc=%0d required none", t); end
    do_read(1'b1, tr);
    gnt_q.push_back(4'b0010);
    wait_set(10, ts, ok);
    bus.wr_req = '0;
    checks++;
    if (!ok || ts != tr + CT_RESET_SET + 1) begin
      failures++; $display("FAIL reset_to_set_gap got cyc=%0d required cyc=%0d", ts, tr + CT_RESET_SET + 1);
    end
    do_read(1'b1, t);
    repeat (DELAY_OUT + 3) @(negedge clk);
  endtask

  task automatic test_empty_read();
    int t, n0;
    apply_reset();
    n0 = oe_seen;
    do_read(1'b0, t);
    checks++;
    if (bus.rd_gnt !== 1'b1 || bus.rd_empty !== 1'b1) begin
      failures++; $display("FAIL empty_read got rd_gnt=%b rd_empty=%b required 1 1", bus.rd_gnt, bus.rd_empty);
    end
    checks++;
    if (bus.cell_full !== 1'b0) begin failures++; $display("FAIL empty_read_full got=%b required=0", bus.cell_full); end
    repeat (10) @(negedge clk);
    checks++;
    if (oe_seen != n0) begin failures++; $display("FAIL empty_read_out_expect got=%0d required=0", oe_seen - n0); end
  endtask

  task automatic test_reset_midflight();
    int t, c0, n0;
    bit ok;
    apply_reset();
    do_write(4'b0001, 4'b0001, t);
    do_read(1'b1, t);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    oe_q.delete();
    gnt_q.delete();
    exp_level = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.out_level !== 1'b0 || bus.cell_full !== 1'b0 || bus.out_expect !== 1'b0) begin
      failures++; $display("FAIL midflight_reset got level=%b full=%b oe=%b required 0 0 0",
                           bus.out_level, bus.cell_full, bus.out_expect);
    end
    rst_n = 1'b1;
    n0 = oe_seen;
    repeat (15) @(negedge clk);
    checks++;
    if (oe_seen != n0 || bus.out_level !== 1'b0) begin
      failures++; $display("FAIL dropped_out_expect got count=%0d level=%b required 0 0", oe_seen - n0, bus.out_level);
    end
    // Cell must be EMPTY with the pointer back at 0: all requesters, immediate grant to 0.
    gnt_q.push_back(4'b0001);
    c0 = cyc;
    bus.wr_req = 4'b1111;
    wait_set(3, t, ok);
    bus.wr_req = '0;
    checks++;
    if (!ok || t != c0 + 1) begin failures++; $display("FAIL empty_after_reset got cyc=%0d required cyc=%0d", t, c0 + 1); end
    do_read(1'b1, t);
    repeat (DELAY_OUT + 3) @(negedge clk);
  endtask

  initial begin
    checks = 0; failures = 0; oe_seen = 0; exp_level = 1'b0;
    rst_n = 1'b0; bus.wr_req = '0; bus.rd_req = 1'b0;
    fork monitor(); join_none
    test_reset();
    test_write_guard();
    test_out_expect();
    test_back_to_back();
    test_full_stall();
    test_empty_read();
    test_reset_midflight();
    checks++;
    if (gnt_q.size() != 0 || oe_q.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain got grants=%0d out_expects=%0d left required 0 0",
                           gnt_q.size(), oe_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
